// File: rtl/color_seq_pkg.sv
// -----------------------------------------------------------------------------
// color_seq_pkg
//   Shared definitions for the TCS34725 colour sample sequencer.
//   - state_t     : sequencer FSM states
//   - CMD_AUTOINC : TCS34725 command byte with auto-increment addressing
//   - DEV_ADDR_DEFAULT, CDATAL, SAT_VALUE : device constants
//   - acc_width() : accumulator width needed to sum 2^avg_log2 16-bit samples
// -----------------------------------------------------------------------------
package color_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_WAIT    = 3'd2,
        ST_NEXT    = 3'd3,
        ST_PUBLISH = 3'd4
    } state_t;

    localparam logic [7:0]  CMD_AUTOINC      = 8'hA0;
    localparam logic [6:0]  DEV_ADDR_DEFAULT = 7'h29;
    localparam logic [7:0]  CDATAL           = 8'h14;
    localparam logic [15:0] SAT_VALUE        = 16'hFFFF;

    // Summing 2^avg_log2 values of 16 bits needs avg_log2 extra bits.
    function automatic int acc_width(input int avg_log2);
        return 16 + avg_log2;
    endfunction

endpackage

// File: rtl/color_accum_bank.sv
// -----------------------------------------------------------------------------
// color_accum_bank
//   NUM_CH per-channel accumulators used to average colour samples.
//   Ports:
//     clk, rst       : clock, asynchronous active-low reset
//     add_en_i       : add data_i into accumulator idx_i this cycle
//     idx_i          : channel index for the add
//     data_i         : 16-bit raw sample
//     clr_i          : clear all accumulators (wins over add_en_i)
//     avg_o          : all accumulators shifted right by AVG_LOG2, channel k
//                      at bits [16k+15:16k] (combinational readout)
// -----------------------------------------------------------------------------
module color_accum_bank
    import color_seq_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int AVG_LOG2 = 2,
    parameter int IW       = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   add_en_i,
    input  logic [IW-1:0]          idx_i,
    input  logic [15:0]            data_i,
    input  logic                   clr_i,
    output logic [16*NUM_CH-1:0]   avg_o
);

    localparam int AW = acc_width(AVG_LOG2);

    logic [AW-1:0] acc_q [NUM_CH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < NUM_CH; k++) begin
                acc_q[k] <= '0;
            end
        end else if (clr_i) begin
            for (int k = 0; k < NUM_CH; k++) begin
                acc_q[k] <= '0;
            end
        end else if (add_en_i) begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (idx_i == IW'(k)) begin
                    acc_q[k] <= acc_q[k] + {{AVG_LOG2{1'b0}}, data_i};
                end
            end
        end
    end

    // Dropping the low AVG_LOG2 bits is the truncating divide by 2^AVG_LOG2.
    always_comb begin
        avg_o = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            avg_o[16*k +: 16] = acc_q[k][AVG_LOG2 +: 16];
        end
    end

endmodule

// File: rtl/color_sample_sequencer.sv
// -----------------------------------------------------------------------------
// color_sample_sequencer
//   Once per PERIOD_CYC cycles reads NUM_CH 16-bit channel registers of a
//   TCS34725 through a shared 2-byte I2C read master, averages each channel
//   over 2^AVG_LOG2 rounds and publishes all averages with a valid strobe.
//   A read that does not complete within TIMEOUT_CYC cycles aborts the
//   averaging set and raises a sticky err flag.
//
//   Ports:
//     clk        : system clock, rising edge
//     rst        : asynchronous active-low reset
//     en         : allows new rounds (sampled only while idle)
//     start_i2c  : one-cycle read request to the I2C master
//     dev_addr   : constant I2C device address
//     reg_addr   : command byte + register address of the current channel
//     busy_i2c   : I2C master busy
//     done_i2c   : one-cycle read completion, data_in valid with it
//     data_in    : read result {high, low}
//     ch_data    : averaged channels, channel k at bits [16k+15:16k]
//     valid      : one-cycle pulse when ch_data updates
//     err        : sticky timeout flag, cleared by the next published set
//     dbg_state  : current FSM state
//     sat        : (COLOR_SAT_DETECT_EN only) a raw sample of the published
//                  set was saturated
//
//   Build option: define COLOR_SAT_DETECT_EN to add the sat output.
//
//   I2C handshake: a request is made only when busy_i2c is low, as a single
//   start_i2c cycle. The master answers with exactly one done_i2c cycle that
//   carries data_in. done_i2c outside the wait state is ignored.
// -----------------------------------------------------------------------------
module color_sample_sequencer
    import color_seq_pkg::*;
#(
    parameter int         NUM_CH      = 4,
    parameter int         AVG_LOG2    = 2,
    parameter logic [7:0] BASE_REG    = CDATAL,
    parameter logic [6:0] DEV_ADDR    = DEV_ADDR_DEFAULT,
    parameter int         PERIOD_CYC  = 100000,
    parameter int         TIMEOUT_CYC = 50000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    output logic                  start_i2c,
    output logic [6:0]            dev_addr,
    output logic [7:0]            reg_addr,
    input  logic                  busy_i2c,
    input  logic                  done_i2c,
    input  logic [15:0]           data_in,
    output logic [16*NUM_CH-1:0]  ch_data,
    output logic                  valid,
    output logic                  err,
    output state_t                dbg_state
`ifdef COLOR_SAT_DETECT_EN
    ,
    output logic                  sat
`endif
);

    localparam int IW = (NUM_CH > 1)      ? $clog2(NUM_CH)      : 1;
    localparam int PW = (PERIOD_CYC > 1)  ? $clog2(PERIOD_CYC)  : 1;
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int RW = (AVG_LOG2 > 0)    ? AVG_LOG2            : 1;

    localparam logic [IW-1:0] LAST_IDX     = IW'(NUM_CH - 1);
    localparam logic [RW-1:0] LAST_ROUND   = RW'((1 << AVG_LOG2) - 1);
    localparam logic [PW-1:0] PERIOD_LAST  = PW'(PERIOD_CYC - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYC - 1);

    // Channel registers are 16 bits wide, so channel idx sits 2*idx above
    // the base; the command bit selects auto-increment for the 2-byte read.
    function automatic logic [7:0] addr_of(input logic [IW-1:0] idx);
        return CMD_AUTOINC | (BASE_REG + {{(7-IW){1'b0}}, idx, 1'b0});
    endfunction

    state_t                state_q;
    logic [IW-1:0]         idx_q;
    logic [RW-1:0]         round_q;
    logic [PW-1:0]         per_cnt_q;
    logic [PW-1:0]         per_cnt_d;
    logic [TW-1:0]         tmo_q;
    logic                  start_q;
    logic [7:0]            reg_addr_q;
    logic [16*NUM_CH-1:0]  ch_data_q;
    logic                  valid_q;
    logic                  err_q;

    logic                  per_wrap;
    logic                  tmo_hit;
    logic                  acc_add;
    logic                  acc_clr;
    logic [16*NUM_CH-1:0]  acc_avg;

    assign per_wrap  = (per_cnt_q == PERIOD_LAST);
    assign per_cnt_d = per_wrap ? '0 : per_cnt_q + 1'b1;
    assign tmo_hit   = (tmo_q == TIMEOUT_LAST);

    // A completion wins over a timeout landing in the same cycle.
    assign acc_add = (state_q == ST_WAIT) && done_i2c;
    assign acc_clr = (state_q == ST_PUBLISH) ||
                     ((state_q == ST_WAIT) && !done_i2c && tmo_hit);

    color_accum_bank #(
        .NUM_CH   (NUM_CH),
        .AVG_LOG2 (AVG_LOG2),
        .IW       (IW)
    ) u_accum (
        .clk      (clk),
        .rst      (rst),
        .add_en_i (acc_add),
        .idx_i    (idx_q),
        .data_i   (data_in),
        .clr_i    (acc_clr),
        .avg_o    (acc_avg)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            round_q    <= '0;
            per_cnt_q  <= '0;
            tmo_q      <= '0;
            start_q    <= 1'b0;
            reg_addr_q <= CMD_AUTOINC | BASE_REG;
            ch_data_q  <= '0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            // The period counter is free-running in every state so round
            // starts stay on a fixed grid; a late round waits for the next wrap.
            per_cnt_q <= per_cnt_d;
            start_q   <= 1'b0;
            valid_q   <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (per_wrap && en) begin
                        idx_q      <= '0;
                        reg_addr_q <= addr_of('0);
                        state_q    <= ST_ISSUE;
                    end
                end

                ST_ISSUE: begin
                    if (!busy_i2c) begin
                        start_q <= 1'b1;
                        tmo_q   <= '0;
                        state_q <= ST_WAIT;
                    end
                end

                ST_WAIT: begin
                    if (done_i2c) begin
                        state_q <= ST_NEXT;
                    end else if (tmo_hit) begin
                        // Abort the whole averaging set; accumulators are
                        // cleared by the bank in this same cycle.
                        err_q   <= 1'b1;
                        round_q <= '0;
                        state_q <= ST_IDLE;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end

                ST_NEXT: begin
                    if (idx_q != LAST_IDX) begin
                        idx_q      <= idx_q + 1'b1;
                        reg_addr_q <= addr_of(idx_q + 1'b1);
                        state_q    <= ST_ISSUE;
                    end else if (round_q == LAST_ROUND) begin
                        round_q <= '0;
                        state_q <= ST_PUBLISH;
                    end else begin
                        round_q <= round_q + 1'b1;
                        state_q <= ST_IDLE;
                    end
                end

                ST_PUBLISH: begin
                    ch_data_q <= acc_avg;
                    valid_q   <= 1'b1;
                    err_q     <= 1'b0;
                    state_q   <= ST_IDLE;
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef COLOR_SAT_DETECT_EN
    logic sat_pend_q;
    logic sat_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sat_pend_q <= 1'b0;
            sat_q      <= 1'b0;
        end else if (state_q == ST_PUBLISH) begin
            sat_q      <= sat_pend_q;
            sat_pend_q <= 1'b0;
        end else if (acc_clr) begin
            sat_pend_q <= 1'b0;
        end else if (acc_add && (data_in == SAT_VALUE)) begin
            sat_pend_q <= 1'b1;
        end
    end

    assign sat = sat_q;
`endif

    assign start_i2c = start_q;
    assign dev_addr  = DEV_ADDR;
    assign reg_addr  = reg_addr_q;
    assign ch_data   = ch_data_q;
    assign valid     = valid_q;
    assign err       = err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_color_sample_sequencer.sv
// -----------------------------------------------------------------------------
// tb_color_sample_sequencer
//   Directed bench: NUM_CH=4, AVG_LOG2=1, PERIOD_CYC=32, TIMEOUT_CYC=20.
//   The I2C master model answers done five cycles after each start_i2c,
//   taking its read data (or a "never answer" marker) from resp_q.
//   Published ch_data is checked against exp_q.
// -----------------------------------------------------------------------------
module tb_color_sample_sequencer;
    import color_seq_pkg::*;

    localparam int NUM_CH      = 4;
    localparam int AVG_LOG2    = 1;
    localparam int PERIOD_CYC  = 32;
    localparam int TIMEOUT_CYC = 20;

    logic        clk;
    logic        rst;
    logic        en;
    logic        start_i2c;
    logic [6:0]  dev_addr;
    logic [7:0]  reg_addr;
    logic        busy_i2c;
    logic        done_i2c;
    logic [15:0] data_in;
    logic [63:0] ch_data;
    logic        valid;
    logic        err;
    state_t      dbg_state;
    logic        sat;

    color_sample_sequencer #(
        .NUM_CH      (NUM_CH),
        .AVG_LOG2    (AVG_LOG2),
        .BASE_REG    (8'h14),
        .DEV_ADDR    (7'h29),
        .PERIOD_CYC  (PERIOD_CYC),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .start_i2c (start_i2c),
        .dev_addr  (dev_addr),
        .reg_addr  (reg_addr),
        .busy_i2c  (busy_i2c),
        .done_i2c  (done_i2c),
        .data_in   (data_in),
        .ch_data   (ch_data),
        .valid     (valid),
        .err       (err),
        .dbg_state (dbg_state)
`ifdef COLOR_SAT_DETECT_EN
        ,
        .sat       (sat)
`endif
    );

`ifndef COLOR_SAT_DETECT_EN
    assign sat = 1'b0;
`endif

    // ---------------- clock / reset / cycle counter ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc++;

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    // ---------------- scoreboard state ----------------
    int checks    = 0;
    int failures  = 0;
    logic [63:0] exp_q[$];
    logic [16:0] resp_q[$];      // bit 16 set: never answer this read
    logic [7:0]  addr_log_q[$];
    int start_cnt       = 0;
    int valid_cnt       = 0;
    int start_cyc_last  = 0;
    int cd              = 0;
    logic [15:0] pend_data;
    logic [16:0] resp;
    logic [63:0] exp_pub;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- I2C master model ----------------
    always @(negedge clk) begin
        done_i2c = 1'b0;
        if (cd > 0) begin
            cd--;
            if (cd == 0) begin
                done_i2c = 1'b1;
                data_in  = pend_data;
            end
        end
        if (rst && start_i2c) begin
            start_cnt++;
            start_cyc_last = cyc;
            addr_log_q.push_back(reg_addr);
            if (resp_q.size() > 0) begin
                resp = resp_q.pop_front();
                if (!resp[16]) begin
                    cd        = 5;
                    pend_data = resp[15:0];
                end
            end else begin
                cd        = 5;
                pend_data = 16'h0;
            end
        end
    end

    // ---------------- publish monitor ----------------
    always @(negedge clk) begin
        if (rst && valid) begin
            valid_cnt++;
            if (exp_q.size() == 0) begin
                check("pub_unexpected", valid_cnt, 0);
            end else begin
                exp_pub = exp_q.pop_front();
                check("ch_data", ch_data, exp_pub);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push_round(input logic [15:0] c0, input logic [15:0] c1,
                              input logic [15:0] c2, input logic [15:0] c3);
        resp_q.push_back({1'b0, c0});
        resp_q.push_back({1'b0, c1});
        resp_q.push_back({1'b0, c2});
        resp_q.push_back({1'b0, c3});
    endtask

    task automatic wait_valid(input int target, input int budget, input string tag);
        int n = 0;
        while (valid_cnt < target && n < budget) begin
            tick();
            n++;
        end
        check(tag, 64'(valid_cnt >= target), 1);
    endtask

    task automatic wait_starts(input int target, input int budget, input string tag);
        int n = 0;
        while (start_cnt < target && n < budget) begin
            tick();
            n++;
        end
        check(tag, 64'(start_cnt >= target), 1);
    endtask

    task automatic wait_state(input state_t s, input int budget, input string tag);
        int n = 0;
        while (dbg_state != s && n < budget) begin
            tick();
            n++;
        end
        check(tag, 64'(dbg_state == s), 1);
    endtask

    task automatic wait_err(input int budget, input string tag);
        int n = 0;
        while (!err && n < budget) begin
            tick();
            n++;
        end
        check(tag, 64'(err), 1);
    endtask

    // ---------------- directed sequence ----------------
    logic [7:0] exp_addr [4];
    logic [7:0] got_addr;
    int s0;
    int rel_cyc;

    initial begin
        exp_addr = '{8'hB4, 8'hB6, 8'hB8, 8'hBA};
        rst      = 1'b0;
        en       = 1'b1;
        busy_i2c = 1'b0;
        done_i2c = 1'b0;
        data_in  = 16'h0;
        repeat (3) tick();

        // Reset values
        check("rst_start_i2c", start_i2c, 0);
        check("rst_reg_addr", reg_addr, 8'hB4);
        check("rst_ch_data", ch_data, 0);
        check("rst_valid", valid, 0);
        check("rst_err", err, 0);
        check("dev_addr", dev_addr, 7'h29);
`ifdef COLOR_SAT_DETECT_EN
        check("rst_sat", sat, 0);
`endif
        rst = 1'b1;

        // Averaging over two rounds
        push_round(16'd100, 16'd200, 16'd300, 16'd400);
        push_round(16'd102, 16'd201, 16'd303, 16'd404);
        exp_q.push_back({16'd402, 16'd301, 16'd200, 16'd101});
        wait_valid(1, 300, "t1_valid_seen");
        tick();
        check("t1_valid_width", valid, 0);
        check("t1_err", err, 0);
        check("t1_addr_count", addr_log_q.size(), 8);
        for (int i = 0; i < 8; i++) begin
            if (addr_log_q.size() > 0) begin
                got_addr = addr_log_q.pop_front();
                check($sformatf("t1_reg_addr_%0d", i), got_addr, exp_addr[i % 4]);
            end
        end

        // Busy hold-off: busy high for 7 cycles from ISSUE entry
        push_round(16'd10, 16'd20, 16'd30, 16'd40);
        busy_i2c = 1'b1;
        wait_state(ST_ISSUE, 100, "t2_issue_seen");
        s0 = start_cnt;
        repeat (7) tick();
        check("t2_no_start_busy", start_cnt - s0, 0);
        busy_i2c = 1'b0;
        tick();
        check("t2_start_on_release", start_i2c, 1);
        tick();
        check("t2_start_width", start_i2c, 0);
        check("t2_start_count", start_cnt - s0, 1);
        wait_starts(s0 + 4, 100, "t2_round_reads");
        wait_state(ST_IDLE, 50, "t2_round_idle");

        // Timeout on ch2
        s0 = start_cnt;
        resp_q.push_back({1'b0, 16'd60});
        resp_q.push_back({1'b0, 16'd70});
        resp_q.push_back({1'b1, 16'd0});
        wait_err(300, "t3_err_seen");
        check("t3_err_delay", cyc - start_cyc_last, TIMEOUT_CYC);
        check("t3_no_valid", valid_cnt, 1);
        check("t3_ch_hold", ch_data, {16'd402, 16'd301, 16'd200, 16'd101});
        check("t3_reads", start_cnt - s0, 3);
        check("t3_idle", 64'(dbg_state == ST_IDLE), 1);

        // Two clean rounds after the abort (ch1 saturates in the first)
        push_round(16'd1000, 16'hFFFF, 16'd3000, 16'd4000);
        push_round(16'd1002, 16'd1, 16'd3001, 16'd4003);
        exp_q.push_back({16'd4001, 16'd3000, 16'd32768, 16'd1001});
        wait_starts(s0 + 7, 200, "t3_round_c_reads");
        check("t3_err_sticky", err, 1);
        wait_valid(2, 300, "t3_publish_seen");
        check("t3_err_cleared", err, 0);
`ifdef COLOR_SAT_DETECT_EN
        check("t3_sat_set", sat, 1);
`endif

        // Enable gating: en drops during the ch1 read
        s0 = start_cnt;
        push_round(16'd7, 16'd8, 16'd9, 16'd10);
        wait_starts(s0 + 2, 200, "t4_ch1_start");
        en = 1'b0;
        repeat (150) tick();
        check("t4_reads_en_low", start_cnt - s0, 4);
        check("t4_no_publish", valid_cnt, 2);
        en = 1'b1;
        push_round(16'd9, 16'd10, 16'd11, 16'd12);
        exp_q.push_back({16'd11, 16'd10, 16'd9, 16'd8});
        wait_valid(3, 300, "t4_publish_seen");
`ifdef COLOR_SAT_DETECT_EN
        check("t4_sat_clear", sat, 0);
`endif

        // Reset in the middle of the ch1 read
        s0 = start_cnt;
        push_round(16'd500, 16'd600, 16'd700, 16'd800);
        wait_starts(s0 + 2, 200, "t5_ch1_start");
        check("t5_pre_start", start_i2c, 1);
        rst = 1'b0;
        #1;
        check("t5_rst_start_i2c", start_i2c, 0);
        check("t5_rst_reg_addr", reg_addr, 8'hB4);
        check("t5_rst_ch_data", ch_data, 0);
        check("t5_rst_valid", valid, 0);
        check("t5_rst_err", err, 0);
`ifdef COLOR_SAT_DETECT_EN
        check("t5_rst_sat", sat, 0);
`endif
        resp_q.delete();
        repeat (3) tick();
        push_round(16'd20, 16'd40, 16'd60, 16'd80);
        push_round(16'd22, 16'd42, 16'd62, 16'd82);
        exp_q.push_back({16'd81, 16'd61, 16'd41, 16'd21});
        s0 = start_cnt;
        rst = 1'b1;
        rel_cyc = cyc;
        wait_starts(s0 + 1, 100, "t5_first_start");
        check("t5_first_start_delay", start_cyc_last - rel_cyc, PERIOD_CYC + 1);
        wait_valid(4, 300, "t5_publish_seen");

        tick();
        check("valid_total", valid_cnt, 4);
        check("exp_q_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
